mem_arbiter: RTL and testbench

- Sits between the instruction-fetch requester (icache) and the load/store buffer on one side, and the byte-serial memory controller on the other.
- Sequences the controller so that at most one transaction is outstanding at any time.
- Applies store-first priority, round-robin between fetch and load, and a starvation bound for fetch.
- Aborts speculative fetches and loads on pipeline clear. Stores are never aborted.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences the icache fetch port and the load/store buffer onto
// a byte-serial memory controller, keeping at most one transaction in flight.
//
// Ports:
//   clk, rst (async, active low), rdy (global enable), clear (pipeline flush)
//   if_req/if_addr -> if_done/if_data           : fetch requester
//   ls_req/ls_wr/ls_len/ls_addr/ls_wdata
//                   -> ls_done/ls_rdata         : load/store requester
//   mc_ins_sig/mc_ins_addr <- mc_ins_done/mc_ins_data      : controller fetch
//   mc_ls_sig/mc_ls_wr/mc_len/mc_ls_addr/mc_store_val
//                   <- mc_ls_done/mc_ls_data    : controller load/store
//   busy : high whenever the arbiter is not idle
//
// Grant priority in IDLE: starved fetch, then store, then round-robin between
// fetch and load. Fetches and loads are dropped on clear; stores always finish.
module mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [63:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [2:0]  ls_len,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        mc_ins_sig,
   output logic [31:0] mc_ins_addr,
   input  logic        mc_ins_done,
   input  logic [63:0] mc_ins_data,
   output logic        mc_ls_sig,
   output logic        mc_ls_wr,
   output logic [2:0]  mc_len,
   output logic [31:0] mc_ls_addr,
   output logic [31:0] mc_store_val,
   input  logic        mc_ls_done,
   input  logic [31:0] mc_ls_data,
   output logic        busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] LSOP  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   localparam int             CW         = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);

   localparam logic GRANT_IF = 1'b0;
   localparam logic GRANT_LS = 1'b1;

   logic [1:0]    state;
   logic          last_grant;
   logic [CW-1:0] starve_cnt;

   logic fetch_ok, load_ok, store_req;
   logic grant_if, grant_ls;

   // Speculative requesters are ineligible while clear is high.
   assign fetch_ok  = if_req && !clear;
   assign load_ok   = ls_req && !ls_wr && !clear;
   assign store_req = ls_req && ls_wr;

   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (fetch_ok && starve_cnt == STARVE_LIM)
         grant_if = 1'b1;
      else if (store_req)
         grant_ls = 1'b1;
      else if (fetch_ok && load_ok) begin
         if (last_grant == GRANT_LS) grant_if = 1'b1;
         else                        grant_ls = 1'b1;
      end
      else if (load_ok)
         grant_ls = 1'b1;
      else if (fetch_ok)
         grant_if = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         last_grant   <= GRANT_LS;
         starve_cnt   <= '0;
         if_done      <= 1'b0;
         if_data      <= '0;
         ls_done      <= 1'b0;
         ls_rdata     <= '0;
         mc_ins_sig   <= 1'b0;
         mc_ins_addr  <= '0;
         mc_ls_sig    <= 1'b0;
         mc_ls_wr     <= 1'b0;
         mc_len       <= '0;
         mc_ls_addr   <= '0;
         mc_store_val <= '0;
         busy         <= 1'b0;
      end
      else begin
         // Done outputs are single-cycle pulses and are suppressed while stalled.
         if_done <= 1'b0;
         ls_done <= 1'b0;
         if (rdy) begin
            case (state)
               IDLE: begin
                  if (grant_if) begin
                     state       <= FETCH;
                     busy        <= 1'b1;
                     mc_ins_sig  <= 1'b1;
                     mc_ins_addr <= if_addr;
                     last_grant  <= GRANT_IF;
                     starve_cnt  <= '0;
                  end
                  else if (grant_ls) begin
                     state        <= LSOP;
                     busy         <= 1'b1;
                     mc_ls_sig    <= 1'b1;
                     mc_ls_wr     <= ls_wr;
                     mc_len       <= ls_len;
                     mc_ls_addr   <= ls_addr;
                     mc_store_val <= ls_wdata;
                     last_grant   <= GRANT_LS;
                     if (!if_req)
                        starve_cnt <= '0;
                     else if (starve_cnt != STARVE_LIM)
                        starve_cnt <= starve_cnt + 1'b1;
                  end
                  else if (!if_req)
                     starve_cnt <= '0;
               end
               FETCH: begin
                  // clear beats a coincident done: the data is discarded.
                  if (clear || mc_ins_done) begin
                     mc_ins_sig <= 1'b0;
                     state      <= GAP;
                     if (!clear) begin
                        if_data <= mc_ins_data;
                        if_done <= 1'b1;
                     end
                  end
               end
               LSOP: begin
                  if (mc_ls_wr) begin
                     // Stores have architectural side effects; never abandoned.
                     if (mc_ls_done) begin
                        ls_done   <= 1'b1;
                        mc_ls_sig <= 1'b0;
                        state     <= GAP;
                     end
                  end
                  else if (clear || mc_ls_done) begin
                     mc_ls_sig <= 1'b0;
                     state     <= GAP;
                     if (!clear) begin
                        ls_rdata <= mc_ls_data;
                        ls_done  <= 1'b1;
                     end
                  end
               end
               default: begin
                  // GAP: one idle cycle lets the controller drop its done pulse.
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   a_sig_excl: assert property (@(posedge clk) disable iff (!rst)
                                !(mc_ins_sig && mc_ls_sig));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        clear = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_done;
   logic [63:0] if_data;
   logic        ls_req = 1'b0;
   logic        ls_wr = 1'b0;
   logic [2:0]  ls_len = '0;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic        mc_ins_sig;
   logic [31:0] mc_ins_addr;
   logic        mc_ins_done = 1'b0;
   logic [63:0] mc_ins_data = '0;
   logic        mc_ls_sig;
   logic        mc_ls_wr;
   logic [2:0]  mc_len;
   logic [31:0] mc_ls_addr;
   logic [31:0] mc_store_val;
   logic        mc_ls_done = 1'b0;
   logic [31:0] mc_ls_data = '0;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mc_ins_sig(mc_ins_sig), .mc_ins_addr(mc_ins_addr),
      .mc_ins_done(mc_ins_done), .mc_ins_data(mc_ins_data),
      .mc_ls_sig(mc_ls_sig), .mc_ls_wr(mc_ls_wr), .mc_len(mc_len),
      .mc_ls_addr(mc_ls_addr), .mc_store_val(mc_store_val),
      .mc_ls_done(mc_ls_done), .mc_ls_data(mc_ls_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("sig_excl", {63'd0, mc_ins_sig && mc_ls_sig}, 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_sigs"}, {60'd0, if_done, ls_done, mc_ins_sig, mc_ls_sig}, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_if_data"}, if_data, 64'd0);
      chk({tag, "_ls_rdata"}, {32'd0, ls_rdata}, 64'd0);
      chk({tag, "_mc_fields"}, {mc_ins_addr, mc_ls_addr}, 64'd0);
      chk({tag, "_mc_misc"}, {mc_store_val, 28'd0, mc_ls_wr, mc_len}, 64'd0);
   endtask

   initial begin
      // ---- reset, asynchronously before any clock edge
      #2 rst = 1'b0;
      #1;
      chk_all_zero("reset");
      tick(); tick();
      rst = 1'b1;

      // ---- lone fetch
      if_addr = 32'h100; if_req = 1'b1;
      tick();
      chk("f1_sig", {63'd0, mc_ins_sig}, 64'd1);
      chk("f1_addr", {32'd0, mc_ins_addr}, 64'h100);
      chk("f1_busy", {63'd0, busy}, 64'd1);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("f1_hold", {62'd0, mc_ins_sig, if_done}, 64'd2);
      end
      mc_ins_done = 1'b1; mc_ins_data = 64'h1122334455667788;
      tick();
      mc_ins_done = 1'b0; if_req = 1'b0;
      chk("f1_done", {63'd0, if_done}, 64'd1);
      chk("f1_data", if_data, 64'h1122334455667788);
      chk("f1_gap", {61'd0, mc_ins_sig, mc_ls_sig, busy}, 64'd1);
      tick();
      chk("f1_idle", {62'd0, if_done, busy}, 64'd0);

      // ---- fetch/load tie straight out of reset: fetch first
      rst = 1'b0; tick(); rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h400;
      ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'd4; ls_addr = 32'h200;
      tick();
      chk("tie_fetch_first", {62'd0, mc_ins_sig, mc_ls_sig}, 64'd2);
      tick();
      mc_ins_done = 1'b1; mc_ins_data = 64'h0123456789ABCDEF;
      tick();
      mc_ins_done = 1'b0; if_req = 1'b0;
      chk("tie_if_done", {63'd0, if_done}, 64'd1);
      tick();
      chk("tie_idle", {62'd0, mc_ls_sig, busy}, 64'd0);
      tick();
      chk("tie_load_sig", {62'd0, mc_ins_sig, mc_ls_sig}, 64'd1);
      chk("tie_load_fields", {mc_ls_addr, 28'd0, mc_ls_wr, mc_len}, {32'h200, 32'd4});
      tick();
      mc_ls_done = 1'b1; mc_ls_data = 32'hDEADBEEF;
      tick();
      mc_ls_done = 1'b0; ls_req = 1'b0;
      chk("tie_ls_done", {62'd0, ls_done, mc_ls_sig}, 64'd2);
      chk("tie_ls_rdata", {32'd0, ls_rdata}, 64'hDEADBEEF);
      tick();

      // ---- store stream with fetch waiting: 4 stores, then the fetch
      if_req = 1'b1; if_addr = 32'h500;
      ls_req = 1'b1; ls_wr = 1'b1; ls_len = 3'd1; ls_addr = 32'h1000; ls_wdata = 32'h55;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("starve_store_grant", {62'd0, mc_ins_sig, mc_ls_sig}, 64'd1);
         mc_ls_done = 1'b1;
         tick();
         mc_ls_done = 1'b0;
         chk("starve_store_done", {63'd0, ls_done}, 64'd1);
         tick();
      end
      tick();
      chk("starve_fetch_grant", {62'd0, mc_ins_sig, mc_ls_sig}, 64'd2);
      chk("starve_cnt_zero", {32'd0, 32'(dut.starve_cnt)}, 64'd0);
      mc_ins_done = 1'b1;
      tick();
      mc_ins_done = 1'b0; if_req = 1'b0; ls_req = 1'b0;
      tick();

      // ---- clear during a load, with a fetch pending
      if_req = 1'b1; if_addr = 32'h600;
      ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'd2; ls_addr = 32'h640;
      tick();
      chk("clr_load_grant", {62'd0, mc_ins_sig, mc_ls_sig}, 64'd1);
      clear = 1'b1;
      tick();
      chk("clr_load_abort", {61'd0, ls_done, mc_ls_sig, busy}, 64'd1);
      tick();
      chk("clr_idle", {63'd0, busy}, 64'd0);
      tick();
      chk("clr_no_grant", {61'd0, mc_ins_sig, mc_ls_sig, busy}, 64'd0);
      clear = 1'b0;
      tick();
      chk("clr_then_fetch", {62'd0, mc_ins_sig, mc_ls_sig}, 64'd2);
      mc_ins_done = 1'b1;
      tick();
      mc_ins_done = 1'b0; if_req = 1'b0;
      tick();
      tick();
      chk("clr_load2_grant", {62'd0, mc_ins_sig, mc_ls_sig}, 64'd1);
      clear = 1'b1; mc_ls_done = 1'b1; mc_ls_data = 32'h12345678;
      tick();
      clear = 1'b0; mc_ls_done = 1'b0; ls_req = 1'b0;
      chk("clr_coinc_done", {62'd0, ls_done, mc_ls_sig}, 64'd0);
      chk("clr_coinc_rdata", {32'd0, ls_rdata}, 64'hDEADBEEF);
      tick();

      // ---- clear during a store: store completes, data stable
      ls_req = 1'b1; ls_wr = 1'b1; ls_len = 3'd4; ls_addr = 32'h30000; ls_wdata = 32'hCAFEBABE;
      tick();
      chk("st_grant", {mc_store_val, 31'd0, mc_ls_sig}, {32'hCAFEBABE, 32'd1});
      clear = 1'b1; ls_wdata = 32'h0;
      tick();
      chk("st_clear_hold", {mc_store_val, 30'd0, mc_ls_sig, ls_done}, {32'hCAFEBABE, 32'd2});
      tick();
      mc_ls_done = 1'b1;
      tick();
      chk("st_done", {mc_store_val, 31'd0, ls_done}, {32'hCAFEBABE, 32'd1});
      chk("st_addr", {32'd0, mc_ls_addr}, 64'h30000);
      clear = 1'b0; mc_ls_done = 1'b0; ls_req = 1'b0;
      tick();

      // ---- asynchronous reset mid-fetch
      if_req = 1'b1; if_addr = 32'h700;
      tick();
      chk("ar_fetch", {62'd0, mc_ins_sig, busy}, 64'd3);
      #2 rst = 1'b0;
      #1;
      chk_all_zero("ar_async");
      tick();
      rst = 1'b1;
      tick();
      chk("ar_regrant", {31'd0, mc_ins_sig, mc_ins_addr}, {32'd1, 32'h700});
      mc_ins_done = 1'b1;
      tick();
      mc_ins_done = 1'b0; if_req = 1'b0;
      tick();

      // ---- rdy low during a load
      ls_req = 1'b1; ls_wr = 1'b0; ls_len = 3'd4; ls_addr = 32'h800;
      tick();
      chk("rdy_grant", {63'd0, mc_ls_sig}, 64'd1);
      rdy = 1'b0; mc_ls_done = 1'b1; mc_ls_data = 32'hAAAA5555;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rdy_stall", {61'd0, ls_done, mc_ls_sig, busy}, 64'd3);
      end
      rdy = 1'b1;
      tick();
      mc_ls_done = 1'b0; ls_req = 1'b0;
      chk("rdy_done", {31'd0, ls_done, ls_rdata}, {32'd1, 32'hAAAA5555});
      tick();
      tick();
      chk("rdy_idle", {63'd0, busy}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
